// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types: data/register-address widths and the buffered
// long-op result entry. WORD and REG_ADDRESS_SPACE may be predefined by the
// build; otherwise a 32-bit word and 5-bit register address are used.
// No ports (package).

`ifndef WORD
`define WORD 32
`endif
`ifndef REG_ADDRESS_SPACE
`define REG_ADDRESS_SPACE 5
`endif

package writeback_arbiter_pkg;

    localparam int unsigned WORD_W     = `WORD;
    localparam int unsigned REG_ADDR_W = `REG_ADDRESS_SPACE;

    // One buffered long-latency result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t for long-latency results.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (discards contents)
//   push, push_entry  enqueue request and entry
//   pop            dequeue request (ignored when empty)
//   head_c         entry at the read pointer
//   empty_c/full_c status decoded from the registered occupancy count
// DEPTH must be a power of two (>= 2); pointers wrap naturally.

module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head_c,
    output logic      empty_c,
    output logic      full_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));
    assign head_c  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so push is allowed when full and popping.
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results (priority) and buffered
// long-latency results onto the register file's single write port, and keeps
// a busy scoreboard of registers with an outstanding long op.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data   long-op result handshake (into FIFO)
//   iss_valid/iss_rd                 long-op issue, marks rd busy
//   rs1_addr/rs2_addr                hazard query addresses
//   hazard1/hazard2                  combinational "not safe to read"
//   busy                             scoreboard vector
//   fwd1_*/fwd2_*                    pending-write bypass (zero unless bypass build)
//   wr_en/wr_addr/wr_data            registered register-file write
// Build option: define WB_BYPASS_EN to forward the pending write instead of
// reporting it as a hazard.

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH        = WORD_W,
    parameter int unsigned ADDR_SPACE   = REG_ADDR_W,
    parameter int unsigned REG_AMOUNT   = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_SPACE-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_SPACE-1:0] mem_rd,
    input  logic [WIDTH-1:0]      mem_data,
    input  logic                  iss_valid,
    input  logic [ADDR_SPACE-1:0] iss_rd,
    input  logic [ADDR_SPACE-1:0] rs1_addr,
    input  logic [ADDR_SPACE-1:0] rs2_addr,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [REG_AMOUNT-1:0] busy,
    output logic                  fwd1_valid,
    output logic [WIDTH-1:0]      fwd1_data,
    output logic                  fwd2_valid,
    output logic [WIDTH-1:0]      fwd2_data,
    output logic                  wr_en,
    output logic [ADDR_SPACE-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             mem_entry;
    wb_entry_t             head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  drain;
    logic                  force_drain;
    logic                  alu_win;
    logic [CNT_W-1:0]      starve_cnt;
    logic [REG_AMOUNT-1:0] busy_set;
    logic [REG_AMOUNT-1:0] busy_clr;
    logic                  pend1;
    logic                  pend2;

    // Arbitration: the counter only reaches the limit with the FIFO non-empty,
    // so a forced cycle always has an entry to drain.
    assign force_drain = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign alu_ready   = !force_drain;
    assign alu_win     = alu_valid && !force_drain;
    assign drain       = !fifo_empty && (force_drain || !alu_valid);

    // mem_ready depends on the registered count only.
    assign mem_ready   = !fifo_full;
    assign push        = mem_valid && mem_ready;

    always_comb begin
        mem_entry.rd   = REG_ADDR_W'(mem_rd);
        mem_entry.data = WORD_W'(mem_data);
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (mem_entry),
        .pop        (drain),
        .head_c     (head),
        .empty_c    (fifo_empty),
        .full_c     (fifo_full)
    );

    // Starvation counter: counts ALU wins that left a waiting FIFO entry behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (drain) begin
            starve_cnt <= '0;
        end else if (alu_win && !fifo_empty) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Write port register; rd==0 results use their slot but never write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (alu_win) begin
            wr_en   <= (alu_rd != '0);
            wr_addr <= alu_rd;
            wr_data <= alu_data;
        end else if (drain) begin
            wr_en   <= (head.rd != '0);
            wr_addr <= ADDR_SPACE'(head.rd);
            wr_data <= WIDTH'(head.data);
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Scoreboard set/clear masks; x0 is never tracked.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && (iss_rd != '0)) busy_set[iss_rd] = 1'b1;
        if (drain && (head.rd != '0))    busy_clr[head.rd] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    // Register-file write landing at the next edge.
    assign pend1 = wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0);
    assign pend2 = wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0);

`ifdef WB_BYPASS_EN
    assign hazard1    = (rs1_addr != '0) && busy[rs1_addr];
    assign hazard2    = (rs2_addr != '0) && busy[rs2_addr];
    assign fwd1_valid = pend1;
    assign fwd1_data  = wr_data;
    assign fwd2_valid = pend2;
    assign fwd2_data  = wr_data;
`else
    assign hazard1    = ((rs1_addr != '0) && busy[rs1_addr]) || pend1;
    assign hazard2    = ((rs2_addr != '0) && busy[rs2_addr]) || pend2;
    assign fwd1_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_valid = 1'b0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a table of single-cycle vectors
// (inputs and hand-computed post-edge outputs) plus hand-written sequences
// for FIFO fill / starvation drain and mid-operation reset.

module tb_writeback_arbiter;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int NV = 15;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] busy;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .busy       (busy),
        .fwd1_valid (fwd1_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_valid (fwd2_valid),
        .fwd2_data  (fwd2_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs for one cycle and the outputs expected just after its edge.
    // hb = busy part of the hazard, pw = pending-write match for that source.
    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [31:0] mem_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_wr_en;
        logic [4:0]  e_wr_addr;
        logic [31:0] e_wr_data;
        logic        e_alu_rdy;
        logic        e_mem_rdy;
        logic [31:0] e_busy;
        logic        hb1;
        logic        pw1;
        logic        hb2;
        logic        pw2;
    } vec_t;

    vec_t vec [NV];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic ar, input logic mr, input logic [31:0] bz,
        input logic h1, input logic p1, input logic h2, input logic p2);
        vec_t v;
        v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
        v.mem_v = mv; v.mem_rd = mrd; v.mem_d = md;
        v.iss_v = iv; v.iss_rd = ird; v.rs1 = r1; v.rs2 = r2;
        v.e_wr_en = we; v.e_wr_addr = wa; v.e_wr_data = wd;
        v.e_alu_rdy = ar; v.e_mem_rdy = mr; v.e_busy = bz;
        v.hb1 = h1; v.pw1 = p1; v.hb2 = h2; v.pw2 = p2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        // alu v/rd/data | mem v/rd/data | iss v/rd | rs1 rs2 || wr_en/addr/data | alu_rdy mem_rdy | busy | hb1 pw1 hb2 pw2
        vec[0]  = mk(1,5,32'h1234, 0,0,0,        0,0, 5,0,  1,5,32'h1234, 1,1, 32'h0,     0,1,0,0); // ALU alone
        vec[1]  = mk(1,3,32'h33,   1,7,32'h77,   0,0, 7,3,  1,3,32'h33,   1,1, 32'h0,     0,0,0,1); // collision: ALU first
        vec[2]  = mk(0,0,0,        0,0,0,        0,0, 7,0,  1,7,32'h77,   1,1, 32'h0,     0,1,0,0); // mem one cycle later
        vec[3]  = mk(0,0,0,        0,0,0,        0,0, 0,0,  0,0,0,        1,1, 32'h0,     0,0,0,0);
        vec[4]  = mk(0,0,0,        0,0,0,        1,9, 9,0,  0,0,0,        1,1, 32'h200,   1,0,0,0); // issue rd9
        vec[5]  = mk(0,0,0,        1,9,32'h99,   0,0, 9,0,  0,0,0,        1,1, 32'h200,   1,0,0,0); // enqueue, not drainable yet
        vec[6]  = mk(0,0,0,        0,0,0,        0,0, 9,0,  1,9,32'h99,   1,1, 32'h0,     0,1,0,0); // write clears busy
        vec[7]  = mk(0,0,0,        1,9,32'hAA,   1,9, 9,0,  0,0,0,        1,1, 32'h200,   1,0,0,0);
        vec[8]  = mk(0,0,0,        0,0,0,        1,9, 9,0,  1,9,32'hAA,   1,1, 32'h200,   1,1,0,0); // set beats clear
        vec[9]  = mk(0,0,0,        1,0,32'h55,   0,0, 0,0,  0,0,0,        1,1, 32'h200,   0,0,0,0); // mem x0 enqueue
        vec[10] = mk(0,0,0,        0,0,0,        0,0, 9,0,  0,0,0,        1,1, 32'h200,   1,0,0,0); // x0 drain: no write
        vec[11] = mk(1,0,32'h1,    0,0,0,        0,0, 0,0,  0,0,0,        1,1, 32'h200,   0,0,0,0); // ALU x0
        vec[12] = mk(0,0,0,        0,0,0,        1,0, 0,0,  0,0,0,        1,1, 32'h200,   0,0,0,0); // issue x0: no busy
        vec[13] = mk(1,4,32'h44,   0,0,0,        0,0, 0,4,  1,4,32'h44,   1,1, 32'h200,   0,0,0,1); // pending write rd4, rs2=4
        vec[14] = mk(1,9,32'hBB,   0,0,0,        0,0, 9,4,  1,9,32'hBB,   1,1, 32'h200,   1,1,0,0); // ALU write to busy reg

        // Reset
        rst_n = 1'b0;
        idle_inputs();
        rs1_addr = 5'd9; rs2_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy", busy, 0);
        chk("rst mem_ready", mem_ready, 1);
        chk("rst alu_ready", alu_ready, 1);
        chk("rst hazard1", hazard1, 0);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            alu_valid = vec[i].alu_v; alu_rd = vec[i].alu_rd; alu_data = vec[i].alu_d;
            mem_valid = vec[i].mem_v; mem_rd = vec[i].mem_rd; mem_data = vec[i].mem_d;
            iss_valid = vec[i].iss_v; iss_rd = vec[i].iss_rd;
            rs1_addr  = vec[i].rs1;   rs2_addr = vec[i].rs2;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wr_en", i), wr_en, vec[i].e_wr_en);
            if (vec[i].e_wr_en) begin
                chk($sformatf("v%0d wr_addr", i), wr_addr, vec[i].e_wr_addr);
                chk($sformatf("v%0d wr_data", i), wr_data, vec[i].e_wr_data);
            end
            chk($sformatf("v%0d alu_ready", i), alu_ready, vec[i].e_alu_rdy);
            chk($sformatf("v%0d mem_ready", i), mem_ready, vec[i].e_mem_rdy);
            chk($sformatf("v%0d busy", i), busy, vec[i].e_busy);
            chk($sformatf("v%0d hazard1", i), hazard1, vec[i].hb1 | (vec[i].pw1 & ~BYP));
            chk($sformatf("v%0d hazard2", i), hazard2, vec[i].hb2 | (vec[i].pw2 & ~BYP));
            chk($sformatf("v%0d fwd1_valid", i), fwd1_valid, vec[i].pw1 & BYP);
            chk($sformatf("v%0d fwd2_valid", i), fwd2_valid, vec[i].pw2 & BYP);
            if (vec[i].pw1 || !BYP)
                chk($sformatf("v%0d fwd1_data", i), fwd1_data, BYP ? vec[i].e_wr_data : 32'h0);
            if (vec[i].pw2 || !BYP)
                chk($sformatf("v%0d fwd2_data", i), fwd2_data, BYP ? vec[i].e_wr_data : 32'h0);
        end

        // Fill under a saturated ALU: items 0..3 enqueue at edges 1..4, item 4
        // waits; 8 ALU wins with the FIFO non-empty (edges 2..9) force a drain
        // at edge 10, after which item 4 enqueues at edge 11.
        idle_inputs();
        rs1_addr = '0; rs2_addr = '0;
        for (int e = 1; e <= 11; e++) begin
            int idx;
            idx = (e <= 4) ? e - 1 : 4;
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(e);
            mem_valid = 1'b1; mem_rd = 5'(10 + idx); mem_data = 32'(256 + idx);
            @(posedge clk);
            #1;
            chk($sformatf("fill e%0d wr_en", e), wr_en, 1);
            chk($sformatf("fill e%0d wr_addr", e), wr_addr, (e == 10) ? 32'd10 : 32'd1);
            chk($sformatf("fill e%0d wr_data", e), wr_data, (e == 10) ? 32'h100 : 32'(e));
            chk($sformatf("fill e%0d alu_ready", e), alu_ready, (e == 9) ? 32'd0 : 32'd1);
            chk($sformatf("fill e%0d mem_ready", e), mem_ready,
                ((e <= 3) || (e == 10)) ? 32'd1 : 32'd0);
        end

        // Stop both sources; one drain leaves three entries buffered.
        idle_inputs();
        @(posedge clk);
        #1;
        chk("drain1 wr_en", wr_en, 1);
        chk("drain1 wr_addr", wr_addr, 11);
        chk("drain1 wr_data", wr_data, 32'h101);
        chk("drain1 mem_ready", mem_ready, 1);
        chk("drain1 busy kept", busy, 32'h200);

        // Reset with three entries pending: all discarded.
        rst_n = 1'b0;
        rs1_addr = 5'd9;
        @(posedge clk);
        #1;
        chk("mrst wr_en", wr_en, 0);
        chk("mrst busy", busy, 0);
        chk("mrst hazard1", hazard1, 0);
        chk("mrst mem_ready", mem_ready, 1);
        chk("mrst alu_ready", alu_ready, 1);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst c%0d wr_en", c), wr_en, 0);
            chk($sformatf("post-rst c%0d mem_ready", c), mem_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
